// File: rtl/rx_burst_if.sv
// Signal bundle between the RF front end / demodulator and the burst receiver.
// clock and reset stay outside the bundle.
interface rx_burst_if #(
    parameter int IQ_BITS = 9
);
    logic                      arm;
    logic                      sample_valid;
    logic signed [IQ_BITS-1:0] rx_inphase;
    logic signed [IQ_BITS-1:0] rx_quadrature;
    logic                      symbol_strobe;
    logic                      symbol_i;
    logic                      is_armed;
    logic                      burst_active;
    logic                      burst_done;
    logic [7:0]                symbols_checked;
    logic [7:0]                bit_errors;
    logic                      truncated;
    logic [7:0]                lfsr;

    modport master (
        output arm, sample_valid, rx_inphase, rx_quadrature, symbol_strobe, symbol_i,
        input  is_armed, burst_active, burst_done, symbols_checked, bit_errors, truncated, lfsr
    );

    modport slave (
        input  arm, sample_valid, rx_inphase, rx_quadrature, symbol_strobe, symbol_i,
        output is_armed, burst_active, burst_done, symbols_checked, bit_errors, truncated, lfsr
    );
endinterface

// File: rtl/rx_burst.sv
// GMSK burst receiver: energy-detects bursts with hysteresis, skips ramp-up symbols,
// then scores hard symbol decisions against a local copy of the transmitter PRBS.
module rx_burst #(
    parameter int             IQ_BITS      = 9,
    parameter logic [IQ_BITS:0] ON_THRESH  = 10'd96,
    parameter logic [IQ_BITS:0] OFF_THRESH = 10'd48,
    parameter int             ON_COUNT     = 8,
    parameter int             OFF_COUNT    = 8,
    parameter int             SKIP_SYMS    = 4,
    parameter int             PAYLOAD_SYMS = 16,
    parameter logic [7:0]     LFSR_TAPS    = 8'h8e
) (
    input  logic       clock,
    input  logic       reset,
    rx_burst_if.slave  bus
);
    localparam int SW = $clog2(SKIP_SYMS + 1);
    localparam int CW = $clog2(PAYLOAD_SYMS + 1);

    typedef enum logic [2:0] {IDLE, HUNT, SKIP, COMPARE, TAIL, DONE} state_t;

    // Two's-complement magnitude; the most negative input maps to 2^(IQ_BITS-1) unsigned.
    function automatic logic [IQ_BITS-1:0] abs_f(input logic signed [IQ_BITS-1:0] x);
        return x[IQ_BITS-1] ? -x : x;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] x);
        return (x == 8'hff) ? x : x + 8'd1;
    endfunction

    function automatic logic [7:0] lfsr_step(input logic [7:0] x);
        return {1'b0, x[7:1]} ^ (x[0] ? LFSR_TAPS : 8'h00);
    endfunction

    logic signed [IQ_BITS-1:0] i_s, q_s;
    logic [IQ_BITS:0]          mag_d;
    logic [IQ_BITS:0]          mag_p1_q;
    logic                      vld_p1_q;
    logic [7:0]                on_run_q, off_run_q;
    logic                      on_hit, off_hit;

    state_t        state_q, state_d;
    logic [7:0]    lfsr_q, lfsr_d;
    logic [SW-1:0] skip_q, skip_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    chk_q, chk_d;
    logic [7:0]    err_q, err_d;
    logic          trunc_q, trunc_d;

    assign i_s   = bus.rx_inphase;
    assign q_s   = bus.rx_quadrature;
    assign mag_d = {1'b0, abs_f(i_s)} + {1'b0, abs_f(q_s)};

    // Stage 1: magnitude capture
    always_ff @(posedge clock) begin
        if (bus.sample_valid) mag_p1_q <= mag_d;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) vld_p1_q <= 1'b0;
        else       vld_p1_q <= bus.sample_valid;
    end

    // Stage 2: threshold compare and saturating run counters
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            on_run_q  <= 8'd0;
            off_run_q <= 8'd0;
        end else if (vld_p1_q) begin
            on_run_q  <= (mag_p1_q >= ON_THRESH) ? sat_inc8(on_run_q)  : 8'd0;
            off_run_q <= (mag_p1_q <  OFF_THRESH) ? sat_inc8(off_run_q) : 8'd0;
        end
    end

    assign on_hit  = on_run_q  >= 8'(ON_COUNT);
    assign off_hit = off_run_q >= 8'(OFF_COUNT);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            lfsr_q  <= 8'h01;
            skip_q  <= '0;
            cnt_q   <= '0;
            chk_q   <= 8'd0;
            err_q   <= 8'd0;
            trunc_q <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            skip_q  <= skip_d;
            cnt_q   <= cnt_d;
            chk_q   <= chk_d;
            err_q   <= err_d;
            trunc_q <= trunc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        skip_d  = skip_q;
        cnt_d   = cnt_q;
        chk_d   = chk_q;
        err_d   = err_q;
        trunc_d = trunc_q;
        case (state_q)
            IDLE: if (bus.arm) state_d = HUNT;
            HUNT: begin
                if (!bus.arm) begin
                    state_d = IDLE;
                end else if (on_hit) begin
                    state_d = SKIP;
                    skip_d  = '0;
                    cnt_d   = '0;
                    chk_d   = 8'd0;
                    err_d   = 8'd0;
                    trunc_d = 1'b0;
                end
            end
            SKIP: begin
                if (off_hit) begin
                    state_d = DONE;
                    trunc_d = 1'b1;
                end else if (bus.symbol_strobe) begin
                    if (skip_q == SW'(SKIP_SYMS - 1)) state_d = COMPARE;
                    else                              skip_d  = skip_q + SW'(1);
                end
            end
            COMPARE: begin
                // An abort takes priority: a strobe landing on the abort cycle is dropped.
                if (off_hit) begin
                    state_d = DONE;
                    trunc_d = 1'b1;
                end else if (bus.symbol_strobe) begin
                    if (bus.symbol_i != lfsr_q[1]) err_d = sat_inc8(err_q);
                    chk_d  = sat_inc8(chk_q);
                    lfsr_d = lfsr_step(lfsr_q);
                    cnt_d  = cnt_q + CW'(1);
                    if (cnt_q == CW'(PAYLOAD_SYMS - 1)) state_d = TAIL;
                end
            end
            TAIL: if (off_hit) state_d = DONE;
            DONE: state_d = bus.arm ? HUNT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.is_armed        = (state_q == HUNT);
    assign bus.burst_active    = (state_q == SKIP) || (state_q == COMPARE) || (state_q == TAIL);
    assign bus.burst_done      = (state_q == DONE);
    assign bus.symbols_checked = chk_q;
    assign bus.bit_errors      = err_q;
    assign bus.truncated       = trunc_q;
    assign bus.lfsr            = lfsr_q;
endmodule

// File: doc/rx_burst.md
Name: rx_burst

Overview:
Receive-side counterpart of the GMSK burst transmitter. It watches I/Q samples from the RF front end and detects burst on/off by energy with hysteresis. It skips the ramp-up symbols, then checks the demodulator's hard symbol decisions against a local copy of the transmitter's PRBS LFSR. For each burst it reports symbol count, bit-error count and truncation status.

Parameters:
IQ_BITS, 9, signed width of each I/Q input
ON_THRESH, 10'd96, |I|+|Q| at or above this counts as energy-on
OFF_THRESH, 10'd48, |I|+|Q| below this counts as energy-off
ON_COUNT, 8, consecutive on-samples needed to declare burst start
OFF_COUNT, 8, consecutive off-samples needed to declare burst end
SKIP_SYMS, 4, symbol strobes discarded after burst start (ramp-up)
PAYLOAD_SYMS, 16, symbols compared per burst
LFSR_TAPS, 8'h8e, Galois LFSR taps; must match the transmitter

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-high reset
arm  input  1  level; enables burst hunting
sample_valid  input  1  rx_inphase/rx_quadrature valid this cycle
rx_inphase  input  IQ_BITS  signed I sample
rx_quadrature  input  IQ_BITS  signed Q sample
symbol_strobe  input  1  one-cycle pulse per demodulated symbol
symbol_i  input  1  hard symbol decision, valid with symbol_strobe
is_armed  output  1  high in HUNT state
burst_active  output  1  high from burst start until burst end or abort
burst_done  output  1  one-cycle pulse; result outputs valid from this cycle
symbols_checked  output  8  symbols compared in the last burst
bit_errors  output  8  mismatches in the last burst; saturates at 255
truncated  output  1  last burst ended before PAYLOAD_SYMS compared
lfsr  output  8  current local PRBS state

Behaviour:
- Reset values: state IDLE; lfsr=8'h01; all other outputs 0; run counters 0.
- Reset is honoured at any time, including mid-burst: all state is cleared, including lfsr.
- Magnitude: abs(I)+abs(Q), computed in IQ_BITS+1 bits unsigned. abs(-256) = 256 with no overflow.
  - Magnitude is registered on sample_valid (pipeline stage 1).
  - Threshold compare and run counters update on the next cycle (stage 2).
- Run counters:
  - on_run increments on each valid sample with mag>=ON_THRESH; any other valid sample clears it.
  - off_run works the same way with mag<OFF_THRESH.
  - Both counters saturate; both hold when no sample is valid.
- State machine:
  - IDLE: arm=1 -> HUNT.
  - HUNT (is_armed=1): on_run reaches ON_COUNT -> SKIP, burst_active=1, skip counter cleared. This happens 2 cycles after the edge that captures the qualifying sample. arm=0 -> IDLE.
  - SKIP: count symbol_strobe; after SKIP_SYMS strobes -> COMPARE. symbols_checked and bit_errors are cleared on entry.
  - COMPARE: on each symbol_strobe, compare symbol_i with lfsr[1].
    - Mismatch increments bit_errors (saturating); symbols_checked increments.
    - Then lfsr advances: if lfsr[0], lfsr <= {0,lfsr[7:1]}^LFSR_TAPS; else lfsr <= {0,lfsr[7:1]}.
    - After PAYLOAD_SYMS comparisons -> TAIL.
  - TAIL: wait for off_run==OFF_COUNT -> DONE.
  - DONE: burst_done=1 for exactly one cycle; burst_active=0. Next state is HUNT if arm else IDLE.
- Abort: off_run reaching OFF_COUNT in SKIP or COMPARE -> DONE with truncated=1.
- truncated=0 only on a normal TAIL exit. It is cleared on entry to SKIP.
- The lfsr persists across bursts; only reset returns it to 8'h01. It advances only on compared symbols, so a truncated burst desynchronises later bursts by design, matching transmitter behaviour only on complete bursts.
- arm deasserted mid-burst: the current burst completes normally; the state machine then enters IDLE.
- Symbol strobes in IDLE, HUNT, TAIL and DONE are ignored.
- A symbol_strobe in the same cycle as an abort is not compared.
- Result outputs hold from burst_done until the next SKIP entry.

Test Plan:
- Reset/hunt: assert reset mid-operation, release, arm=1 -> lfsr=8'h01, outputs 0, is_armed=1 two cycles later.
- Clean burst: 10 samples I=+100,Q=0, then SKIP_SYMS junk symbols, then 16 correct PRBS symbols (first four 0,1,1,0), then 10 zero samples -> burst_done pulse, symbols_checked=16, bit_errors=0, truncated=0, lfsr equals the state after 16 advances.
- Errors: same burst with symbols 3 and 9 inverted -> bit_errors=2, symbols_checked=16.
- Hysteresis: alternate mag=100 and mag=60 samples -> never leaves HUNT. Seven samples of 100 then one of 60, repeated -> no start.
- Truncation: energy drops after 5 compared symbols -> burst_done, truncated=1, symbols_checked=5, lfsr advanced 5 steps.
- Extremes: I=-256,Q=-256 -> mag=512, qualifies as on. 300 mismatching symbols with PAYLOAD_SYMS=300 -> bit_errors=255.
